// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared types and helpers for the ECC scrub controller.
// FSM encoding, default entry widths and saturating increment.
package ecc_scrub_pkg;

   localparam int DATA_WIDTH   = 39;
   localparam int PARITY_WIDTH = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_CHECK,
      S_FIX,
      S_WRITE
   } state_t;

   // w is the live counter width; values beyond w bits are never passed
   function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                           input int unsigned w);
      logic [31:0] mx;
      mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v == mx) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ecc_scrub_cnt.sv
// ecc_scrub_cnt: saturating event counter with synchronous clear.
// Clear has priority over a coincident increment.
module ecc_scrub_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   import ecc_scrub_pkg::*;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= W'(sat_inc(32'(cnt), W));
   end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background SEC-DED scrubber sharing the memory port.
// The functional path always wins the port; scrub accesses wait for it.
module ecc_scrub_ctrl #(
   parameter int DATA_WIDTH   = ecc_scrub_pkg::DATA_WIDTH,
   parameter int PARITY_WIDTH = ecc_scrub_pkg::PARITY_WIDTH,
   parameter int ADDR_WIDTH   = 8,
   parameter int DEPTH        = 256,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    scrub_en,
   input  logic [15:0]             interval,
   input  logic                    clr_cnt,
   input  logic                    func_req,
   input  logic                    func_we,
   input  logic [ADDR_WIDTH-1:0]   func_addr,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [PARITY_WIDTH-1:0] mem_wparity,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic [PARITY_WIDTH-1:0] mem_rparity,
   output logic [DATA_WIDTH-1:0]   chk_data_o,
   output logic [PARITY_WIDTH-1:0] chk_parity_o,
   input  logic [DATA_WIDTH-1:0]   chk_data_i,
   input  logic [PARITY_WIDTH-1:0] chk_parity_i,
   input  logic                    chk_sbit,
   input  logic                    chk_dbit,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [ADDR_WIDTH-1:0]   dbit_addr,
   output logic                    dbit_flag,
   output logic                    pass_done,
   output logic                    busy
);
   import ecc_scrub_pkg::*;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [15:0]             ivl_cnt;
   logic [DATA_WIDTH-1:0]   cw;
   logic [PARITY_WIDTH-1:0] np;
   logic                    abort;
   logic                    issue, wr, advance;
   logic                    sinc, dinc;
   logic                    last, hit;

   assign last = (addr == ADDR_WIDTH'(DEPTH - 1));
   assign hit  = func_req & func_we & (func_addr == addr);

   always_comb begin
      state_nx     = state;
      issue        = 1'b0;
      wr           = 1'b0;
      advance      = 1'b0;
      sinc         = 1'b0;
      dinc         = 1'b0;
      chk_data_o   = '0;
      chk_parity_o = '0;
      unique case (state)
         S_IDLE:
            if (scrub_en) state_nx = S_WAIT;
         S_WAIT:
            if (!scrub_en)         state_nx = S_IDLE;
            else if (ivl_cnt <= 1) state_nx = S_READ;
         S_READ:
            if (!func_req) begin
               issue    = 1'b1;
               state_nx = S_CHECK;
            end
         S_CHECK: begin
            chk_data_o   = mem_rdata;
            chk_parity_o = mem_rparity;
            if (chk_dbit) begin
               dinc    = 1'b1;
               advance = 1'b1;
            end else if (chk_sbit) begin
               sinc     = 1'b1;
               state_nx = S_FIX;
            end else begin
               advance = 1'b1;
            end
         end
         S_FIX: begin
            chk_data_o = cw;
            state_nx   = S_WRITE;
         end
         S_WRITE:
            if (!func_req) begin
               wr      = ~abort;
               advance = 1'b1;
            end
         default: state_nx = S_IDLE;
      endcase
      if (advance) state_nx = scrub_en ? S_WAIT : S_IDLE;
   end

   // Port grants are gated so nothing reaches memory during a reset cycle
   assign mem_en      = rst_n & (issue | wr);
   assign mem_we      = rst_n & wr;
   assign mem_addr    = addr;
   assign mem_wdata   = cw;
   assign mem_wparity = np;
   assign busy        = (state != S_IDLE) && (state != S_WAIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr      <= '0;
         ivl_cnt   <= '0;
         cw        <= '0;
         np        <= '0;
         abort     <= 1'b0;
         pass_done <= 1'b0;
         dbit_addr <= '0;
         dbit_flag <= 1'b0;
      end else begin
         state     <= state_nx;
         pass_done <= advance & last;
         if (scrub_en && ((state == S_IDLE) || advance))
            ivl_cnt <= interval;
         else if ((state == S_WAIT) && (ivl_cnt != 0))
            ivl_cnt <= ivl_cnt - 16'd1;
         if (advance)
            addr <= last ? '0 : addr + 1'b1;
         if (sinc)
            cw <= chk_data_i;
         if (state == S_FIX)
            np <= chk_parity_i;
         // A functional write after our read makes the corrected word stale
         if (issue)
            abort <= 1'b0;
         else if (hit && ((state == S_CHECK) || (state == S_FIX) ||
                          (state == S_WRITE)))
            abort <= 1'b1;
         if (clr_cnt) begin
            dbit_addr <= '0;
            dbit_flag <= 1'b0;
         end else if (dinc && !dbit_flag) begin
            dbit_addr <= addr;
            dbit_flag <= 1'b1;
         end
      end
   end

   ecc_scrub_cnt #(.W(CNT_WIDTH)) u_sbit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (sinc),
      .cnt   (sbit_cnt)
   );

   ecc_scrub_cnt #(.W(CNT_WIDTH)) u_dbit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (dinc),
      .cnt   (dbit_cnt)
   );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: scoreboard bench with a memory model and a real
// Hamming SEC-DED checker; small DEPTH and counter width for boundaries.
module tb_ecc_scrub_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 6;
   localparam int CW    = 4;
   localparam int DW    = 39;
   localparam int PW    = 7;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scrub_en = 1'b0;
   logic [15:0]   interval = '0;
   logic          clr_cnt = 1'b0;
   logic          func_req = 1'b0;
   logic          func_we = 1'b0;
   logic [AW-1:0] func_addr = '0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [PW-1:0] mem_wparity;
   logic [DW-1:0] mem_rdata = '0;
   logic [PW-1:0] mem_rparity = '0;
   logic [DW-1:0] chk_data_o, chk_data_i;
   logic [PW-1:0] chk_parity_o, chk_parity_i;
   logic          chk_sbit, chk_dbit;
   logic [CW-1:0] sbit_cnt, dbit_cnt;
   logic [AW-1:0] dbit_addr;
   logic          dbit_flag, pass_done, busy;

   ecc_scrub_ctrl #(
      .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW),
      .DEPTH(DEPTH), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
      .interval(interval), .clr_cnt(clr_cnt),
      .func_req(func_req), .func_we(func_we), .func_addr(func_addr),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wparity(mem_wparity),
      .mem_rdata(mem_rdata), .mem_rparity(mem_rparity),
      .chk_data_o(chk_data_o), .chk_parity_o(chk_parity_o),
      .chk_data_i(chk_data_i), .chk_parity_i(chk_parity_i),
      .chk_sbit(chk_sbit), .chk_dbit(chk_dbit),
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
      .dbit_addr(dbit_addr), .dbit_flag(dbit_flag),
      .pass_done(pass_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Hamming(45,39) + overall parity: data sits at non-power-of-2 positions
   function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
      logic [PW-1:0] p;
      int j;
      p = '0;
      j = 0;
      for (int pos = 1; pos < 46; pos++)
         if ((pos & (pos - 1)) != 0) begin
            if (d[j]) p[5:0] = p[5:0] ^ pos[5:0];
            j++;
         end
      p[6] = (^d) ^ (^p[5:0]);
      return p;
   endfunction

   function automatic logic [DW+1:0] dec(input logic [DW-1:0] d,
                                         input logic [PW-1:0] p);
      logic [PW-1:0] e;
      logic [5:0]    syn;
      logic          ov, sb, db;
      logic [DW-1:0] c;
      int            j;
      e   = enc(d);
      syn = p[5:0] ^ e[5:0];
      ov  = ^{d, p};
      c   = d;
      sb  = 1'b0;
      db  = 1'b0;
      if (!ov) begin
         db = (syn != 0);
      end else if (syn > 6'd45) begin
         db = 1'b1;
      end else begin
         sb = 1'b1;
         j  = 0;
         for (int pos = 1; pos < 46; pos++)
            if ((pos & (pos - 1)) != 0) begin
               if (pos == int'(syn)) c[j] = ~c[j];
               j++;
            end
      end
      return {db, sb, c};
   endfunction

   logic [DW+1:0] dres;
   always_comb begin
      dres         = dec(chk_data_o, chk_parity_o);
      chk_data_i   = dres[DW-1:0];
      chk_sbit     = dres[DW];
      chk_dbit     = dres[DW+1];
      chk_parity_i = enc(chk_data_o);
   end

   logic [DW-1:0] mem_d [16];
   logic [PW-1:0] mem_p [16];
   logic          tb_we = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [DW-1:0] tb_d = '0;
   logic [PW-1:0] tb_p = '0;
   logic [DW-1:0] func_wd = '0;

   always @(posedge clk) begin
      if (mem_en && !mem_we) begin
         mem_rdata   <= mem_d[mem_addr];
         mem_rparity <= mem_p[mem_addr];
      end
      if (mem_en && mem_we) begin
         mem_d[mem_addr] <= mem_wdata;
         mem_p[mem_addr] <= mem_wparity;
      end
      if (func_req && func_we) begin
         mem_d[func_addr] <= func_wd;
         mem_p[func_addr] <= enc(func_wd);
      end
      if (tb_we) begin
         mem_d[tb_addr] <= tb_d;
         mem_p[tb_addr] <= tb_p;
      end
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [PW-1:0] p;
   } txn_t;

   txn_t exp_q[$];
   int   rd_cyc_q[$];
   int   wr_cyc_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pass_seen = 0;

   always @(negedge clk) begin
      txn_t e;
      if (rst_n) begin
         if (pass_done) pass_seen++;
         if (mem_en) begin
            checks++;
            if (func_req) begin
               errors++;
               $display("FAIL port_conflict: mem_en=1 with func_req=1 at cyc %0d",
                        cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_access: we=%0b addr=%0d, none expected",
                        mem_we, mem_addr);
            end else begin
               e = exp_q.pop_front();
               if (e.we !== mem_we || e.a !== mem_addr ||
                   (e.we && (e.d !== mem_wdata || e.p !== mem_wparity))) begin
                  errors++;
                  $display("FAIL txn: got we=%0b a=%0d d=%h p=%h, expected we=%0b a=%0d d=%h p=%h",
                           mem_we, mem_addr, mem_wdata, mem_wparity,
                           e.we, e.a, e.d, e.p);
               end
            end
            if (mem_we) wr_cyc_q.push_back(cyc);
            else        rd_cyc_q.push_back(cyc);
         end
      end
   end

   logic [DW-1:0] g_d [16];
   logic [PW-1:0] g_p [16];
   int            err_kind [16];
   int            m_addr = 0, m_sbit = 0, m_dbit = 0, m_pass = 0;
   int            m_daddr = 0;
   bit            m_flag = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bench_write(input int a, input logic [DW-1:0] d,
                              input logic [PW-1:0] p);
      @(posedge clk); #1;
      tb_we = 1'b1; tb_addr = AW'(a); tb_d = d; tb_p = p;
      @(posedge clk); #1;
      tb_we = 1'b0;
   endtask

   task automatic corrupt(input int a, input logic [DW-1:0] mask,
                          input int kind);
      bench_write(a, g_d[a] ^ mask, g_p[a]);
      err_kind[a] = kind;
   endtask

   function automatic logic [DW-1:0] rand_mask(input int nbits);
      logic [DW-1:0] m;
      int b0, b1;
      b0 = $urandom_range(DW - 1);
      b1 = (b0 + 1 + $urandom_range(DW - 2)) % DW;
      m = '0;
      m[b0] = 1'b1;
      if (nbits == 2) m[b1] = 1'b1;
      return m;
   endfunction

   // Reference: one scrubbed entry in address order, by error kind
   function automatic void plan_entry();
      txn_t t;
      int a;
      a = m_addr;
      t.we = 1'b0; t.a = AW'(a); t.d = '0; t.p = '0;
      exp_q.push_back(t);
      if (err_kind[a] == 1) begin
         t.we = 1'b1; t.d = g_d[a]; t.p = g_p[a];
         exp_q.push_back(t);
         m_sbit = (m_sbit < CMAX) ? m_sbit + 1 : CMAX;
         err_kind[a] = 0;
      end else if (err_kind[a] == 2) begin
         m_dbit = (m_dbit < CMAX) ? m_dbit + 1 : CMAX;
         if (!m_flag) begin
            m_flag  = 1'b1;
            m_daddr = a;
         end
      end
      m_addr = (a + 1) % DEPTH;
      if (m_addr == 0) m_pass++;
   endfunction

   task automatic drain();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_in_time", int'(t < 300), 1);
   endtask

   task automatic run(input int n, input int ivl, input int frate);
      int target, t;
      for (int i = 0; i < n; i++) plan_entry();
      target   = rd_cyc_q.size() + n;
      interval = 16'(ivl);
      scrub_en = 1'b1;
      t = 0;
      while (rd_cyc_q.size() < target && t < 3000) begin
         @(posedge clk); #1;
         func_req  = (frate != 0) && ($urandom_range(99) < frate);
         func_we   = 1'b0;
         func_addr = AW'($urandom);
         t++;
      end
      scrub_en = 1'b0;
      func_req = 1'b0;
      check("reads_in_time", int'(t < 3000), 1);
      drain();
   endtask

   task automatic wait_read();
      int n, t;
      n = rd_cyc_q.size();
      t = 0;
      while (rd_cyc_q.size() == n && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("read_seen", int'(rd_cyc_q.size() > n), 1);
   endtask

   task automatic check_model(input string tag);
      @(negedge clk); #1;
      check({tag, "_sbit_cnt"}, int'(sbit_cnt), m_sbit);
      check({tag, "_dbit_cnt"}, int'(dbit_cnt), m_dbit);
      check({tag, "_dbit_flag"}, int'(dbit_flag), int'(m_flag));
      check({tag, "_dbit_addr"}, int'(dbit_addr), m_flag ? m_daddr : 0);
      check({tag, "_pass_done"}, pass_seen, m_pass);
   endtask

   task automatic clear_counts();
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      m_sbit = 0; m_dbit = 0; m_flag = 1'b0; m_daddr = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall;
      for (int i = 0; i < 16; i++) begin
         g_d[i] = DW'({$urandom, $urandom});
         g_p[i] = enc(g_d[i]);
         err_kind[i] = 0;
         bench_write(i, g_d[i], g_p[i]);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_sbit_cnt", int'(sbit_cnt), 0);
      check("rst_dbit_cnt", int'(dbit_cnt), 0);
      check("rst_dbit_flag", int'(dbit_flag), 0);
      check("rst_dbit_addr", int'(dbit_addr), 0);
      check("rst_pass_done", int'(pass_done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_mem_en", int'(mem_en), 0);
      check("rst_chk_data", int'(chk_data_o != 0), 0);

      // Clean pass, interval 2: reads four cycles apart, no writes
      rd_cyc_q.delete();
      run(DEPTH, 2, 0);
      for (int i = 1; i < DEPTH; i++)
         check("read_spacing", rd_cyc_q[i] - rd_cyc_q[i-1], 4);
      check_model("clean");

      // One correctable and two uncorrectable entries
      begin
         logic [DW-1:0] m;
         m = '0; m[5] = 1'b1;
         corrupt(2, m, 1);
         m = '0; m[0] = 1'b1; m[20] = 1'b1;
         corrupt(1, m, 2);
         m = '0; m[7] = 1'b1; m[38] = 1'b1;
         corrupt(3, m, 2);
      end
      run(DEPTH, 1, 0);
      check_model("errs");
      check("entry2_restored",
            int'(mem_d[2] == g_d[2] && mem_p[2] == g_p[2]), 1);
      bench_write(1, g_d[1], g_p[1]); err_kind[1] = 0;
      bench_write(3, g_d[3], g_p[3]); err_kind[3] = 0;
      clear_counts();
      check_model("clr");

      // Functional stall in READ, then in WRITE
      corrupt(m_addr, rand_mask(1), 1);
      plan_entry();
      rd_cyc_q.delete();
      wr_cyc_q.delete();
      interval = 16'd0;
      @(posedge clk); #1;
      func_req = 1'b1;
      scrub_en = 1'b1;
      repeat (12) @(posedge clk);
      #1 func_req = 1'b0;
      fall = cyc;
      @(negedge clk); #1;
      check("read_after_stall",
            int'(rd_cyc_q.size() == 1 && rd_cyc_q[0] == fall), 1);
      @(posedge clk); #1;
      scrub_en = 1'b0;
      func_req = 1'b1;
      repeat (12) @(posedge clk);
      #1 func_req = 1'b0;
      fall = cyc;
      @(negedge clk); #1;
      check("write_after_stall",
            int'(wr_cyc_q.size() == 1 && wr_cyc_q[0] == fall), 1);
      drain();
      check_model("stall");

      // Functional write to the scrub address before writeback
      begin
         txn_t t;
         int a;
         a = m_addr;
         corrupt(a, rand_mask(1), 1);
         t.we = 1'b0; t.a = AW'(a); t.d = '0; t.p = '0;
         exp_q.push_back(t);
         m_sbit = (m_sbit < CMAX) ? m_sbit + 1 : CMAX;
         err_kind[a] = 0;
         m_addr = (a + 1) % DEPTH;
         scrub_en = 1'b1;
         wait_read();
         @(posedge clk); #1;
         scrub_en  = 1'b0;
         func_req  = 1'b1;
         func_we   = 1'b1;
         func_addr = AW'(a);
         func_wd   = DW'({$urandom, $urandom});
         g_d[a]    = func_wd;
         g_p[a]    = enc(func_wd);
         @(posedge clk); #1;
         func_req = 1'b0;
         func_we  = 1'b0;
         drain();
         check_model("abort");
         check("abort_keeps_func_data",
               int'(mem_d[a] == g_d[a] && mem_p[a] == g_p[a]), 1);
      end

      // Randomised passes with functional traffic
      for (int pass = 0; pass < 4; pass++) begin
         for (int a = 0; a < DEPTH; a++) begin
            int r;
            r = $urandom_range(5);
            if (r < 2)
               corrupt(a, rand_mask(1), 1);
            else if (r == 2)
               corrupt(a, rand_mask(2), 2);
            else if (r == 3 && err_kind[a] == 2) begin
               bench_write(a, g_d[a], g_p[a]);
               err_kind[a] = 0;
            end
         end
         run(DEPTH, $urandom_range(3), 25);
         check_model("rand");
      end

      // Enough correctable errors to reach saturation
      for (int pass = 0; pass < 3; pass++) begin
         for (int a = 0; a < DEPTH; a++)
            corrupt(a, rand_mask(1), 1);
         run(DEPTH, 0, 10);
      end
      check_model("sat");
      check("sbit_saturated", int'(sbit_cnt), CMAX);

      // Clear coinciding with an increment
      corrupt(m_addr, rand_mask(1), 1);
      plan_entry();
      interval = 16'd0;
      scrub_en = 1'b1;
      wait_read();
      @(posedge clk); #1;
      scrub_en = 1'b0;
      clr_cnt  = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      m_sbit = 0; m_dbit = 0; m_flag = 1'b0; m_daddr = 0;
      drain();
      check_model("clr_vs_inc");
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for the ECC-protected FIFO/SRAM, which holds 39-bit data plus 7-bit SEC-DED parity per entry. It walks every address in turn, reads the entry and passes it through the external 39/7 SEC-DED check block. Single-bit errors are corrected and the entry is written back. Double-bit errors are counted and their address is logged. It shares the single memory port with the functional path; the functional path always has priority.

Parameters:
DATA_WIDTH, 39, data bits per entry
PARITY_WIDTH, 7, parity bits per entry
ADDR_WIDTH, 8, memory address width
DEPTH, 256, entries scrubbed per pass (must be at most 2**ADDR_WIDTH)
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
scrub_en  in  1  enable scrubbing
interval  in  16  idle cycles between entry scrubs
clr_cnt  in  1  clear counters and log
func_req  in  1  functional access to memory this cycle
func_we  in  1  functional access is a write
func_addr  in  ADDR_WIDTH  functional address
mem_en  out  1  scrub memory access (asserted only when func_req=0)
mem_we  out  1  scrub write
mem_addr  out  ADDR_WIDTH  scrub address
mem_wdata  out  DATA_WIDTH  corrected write data
mem_wparity  out  PARITY_WIDTH  recomputed parity
mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after read
mem_rparity  in  PARITY_WIDTH  read parity, valid 1 cycle after read
chk_data_o  out  DATA_WIDTH  checker data input
chk_parity_o  out  PARITY_WIDTH  checker parity input
chk_data_i  in  DATA_WIDTH  checker corrected data (combinational)
chk_parity_i  in  PARITY_WIDTH  checker encoded parity of chk_data_o (combinational)
chk_sbit  in  1  checker single-bit error
chk_dbit  in  1  checker double-bit error
sbit_cnt  out  CNT_WIDTH  corrected-error count, saturating
dbit_cnt  out  CNT_WIDTH  uncorrectable-error count, saturating
dbit_addr  out  ADDR_WIDTH  address of first double-bit error since clear
dbit_flag  out  1  sticky: a double-bit error has occurred
pass_done  out  1  1-cycle pulse when the last address has been scrubbed
busy  out  1  FSM is not IDLE and not WAIT

Behaviour:
- Reset: all outputs 0; FSM in IDLE; scrub address 0; interval counter 0; all registers cleared.
- FSM states: IDLE, WAIT, READ, CHECK, FIX, WRITE.
- IDLE: if scrub_en=1, go to WAIT and load the interval counter with interval.
- WAIT: decrement the counter each cycle. At 0, go to READ. If interval=0, WAIT lasts exactly 1 cycle.
- READ: when func_req=0, assert mem_en=1, mem_we=0, mem_addr=scrub address, then go to CHECK. When func_req=1, hold in READ with mem_en=0.
- CHECK (rdata valid this cycle): drive chk_data_o/chk_parity_o from mem_rdata/mem_rparity.
  - No error: advance.
  - chk_dbit=1: increment dbit_cnt; if dbit_flag=0, capture dbit_addr; set dbit_flag; advance.
  - chk_sbit=1: increment sbit_cnt; register chk_data_i as the corrected word; go to FIX.
- FIX: drive chk_data_o = corrected word, chk_parity_o = 0. Register chk_parity_i as the new parity. Go to WRITE.
- WRITE: when func_req=0, assert mem_en=1, mem_we=1, mem_wdata = corrected word, mem_wparity = new parity, then advance. When func_req=1, stall in WRITE.
- Stale-writeback hazard: a functional write (func_req and func_we) to the scrub address in any cycle from READ issue through WRITE sets an abort flag. With the flag set, WRITE issues no memory write and advances. sbit_cnt keeps its increment.
- Advance: address+1 modulo DEPTH. On wrap from DEPTH-1 to 0, pulse pass_done. Then go to WAIT if scrub_en=1, else IDLE.
- scrub_en deasserted mid-sequence: finish the current entry, including any writeback, then go to IDLE. The address is kept for resume.
- chk_data_o/chk_parity_o: 0 in states other than CHECK and FIX.
- Counters: saturate at all-ones and never wrap.
- clr_cnt: clears sbit_cnt, dbit_cnt, dbit_addr and dbit_flag next cycle. If clr_cnt coincides with an increment, the clear wins.
- chk_sbit and chk_dbit both high (not expected): treat as dbit.
- Reset mid-operation: return to IDLE, address 0; no memory write is issued in the reset cycle.

Decomposition:
- Package ecc_scrub_pkg: FSM state enum, DATA_WIDTH/PARITY_WIDTH constants, saturating-increment function.
- Sub-module: ecc_scrub_cnt, a saturating counter with clear, instantiated for sbit_cnt and dbit_cnt.
- The checker stays external.

Test Plan:
- Clean memory, DEPTH=4, interval=2 -> exactly 4 reads at addresses 0,1,2,3 spaced 4 cycles apart; pass_done pulses once after address 3; no writes; counters stay 0.
- Entry 2 with data bit 5 flipped -> write at address 2 with the original data and original parity; sbit_cnt=1.
- Entries 1 and 3 with 2-bit errors -> dbit_cnt=2, dbit_addr=1, dbit_flag=1, no writes.
- func_req held high for 10 cycles during READ, then during WRITE -> mem_en stays 0 throughout; the access issues the cycle after func_req falls.
- Functional write to the scrub address between the scrub read and WRITE on an sbit entry -> no scrub write; sbit_cnt incremented.
- Force sbit_cnt to 0xFFFF then inject an error -> stays 0xFFFF; clr_cnt asserted on the same cycle as an increment -> counter reads 0.
